ms_delay_timer: RTL

Millisecond delay timer that consumes the `pluse_ms` / `pluse_us` tick stream from the clock/reset block and turns it into a start/done delay service for control logic such as VFD refresh, debounce and power sequencing. A requester loads a delay in milliseconds and pulses `start`. The block aligns to the next millisecond boundary, counts whole milliseconds, and then raises a one-cycle `done`. An optional checker verifies that the incoming tick stream really carries 1000 µs per ms.

---
 rtl/ms_delay_timer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ms_delay_timer.sv
// ms_delay_timer: start/done millisecond delay service driven by the
// pluse_ms / pluse_us tick stream. A request aligns to the next ms boundary,
// counts load_ms whole milliseconds, then pulses done for one cycle.
// Optional tick-stream checker: define MS_TICK_CHECK_EN to verify that every
// ms period carries exactly 1000 us ticks (sticky tick_err).
//
// Handshake: start is a one-cycle request honoured only while busy is low and
// abort is low; done is a one-cycle completion pulse; abort cancels any
// pending delay (including a done in the same cycle).
module ms_delay_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             pluse_ms,
    input  logic             pluse_us,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] load_ms,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remain_ms,
    output logic             tick_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic [WIDTH-1:0] remain_q;
    logic             pluse_ms_d_q;
    logic             tick;
    logic             start_acc;

    // A ms tick is the rising edge of pluse_ms, however long it stays high.
    assign tick      = pluse_ms & ~pluse_ms_d_q;
    assign start_acc = (state_q == ST_IDLE) & start & ~abort;

    // Delay line for pluse_ms edge detection; cleared to 0 so a level that is
    // already high when reset releases still yields one tick.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pluse_ms_d_q <= 1'b0;
        end else begin
            pluse_ms_d_q <= pluse_ms;
        end
    end

    // Delay FSM: IDLE -> SYNC (align to ms boundary) -> RUN (count) -> DONE.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
        end else if (abort && (state_q != ST_IDLE)) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_acc) begin
                        if (load_ms == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            remain_q <= load_ms;
                            state_q  <= ST_SYNC;
                        end
                    end
                end
                ST_SYNC: begin
                    // The aligning tick is not counted.
                    if (tick) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // remain_q is at least 1 here, so it never wraps.
                    if (tick) begin
                        if (remain_q == ONE) begin
                            remain_q <= '0;
                            state_q  <= ST_DONE;
                        end else begin
                            remain_q <= remain_q - ONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE);
    // abort in the DONE cycle swallows that cycle's completion pulse.
    assign done      = (state_q == ST_DONE) & ~abort;
    assign remain_ms = remain_q;

`ifdef MS_TICK_CHECK_EN
    logic [10:0] us_cnt_q;
    logic        chk_armed_q;
    logic        tick_err_q;
    logic [11:0] us_total;

    // us ticks seen in the ms period that this tick closes.
    assign us_total = {1'b0, us_cnt_q} + {11'd0, pluse_us};

    // Tick-stream checker: counts us ticks per ms and flags any period that is
    // not exactly 1000 us, once armed by a first tick.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            us_cnt_q    <= '0;
            chk_armed_q <= 1'b0;
            tick_err_q  <= 1'b0;
        end else begin
            if (tick) begin
                us_cnt_q <= '0;
            end else if (pluse_us && (us_cnt_q != 11'h7FF)) begin
                us_cnt_q <= us_cnt_q + 11'd1;
            end
            if (start_acc) begin
                chk_armed_q <= 1'b0;
                tick_err_q  <= 1'b0;
            end else if (tick) begin
                chk_armed_q <= 1'b1;
                if (chk_armed_q && (us_total != 12'd1000)) begin
                    tick_err_q <= 1'b1;
                end
            end
        end
    end

    assign tick_err = tick_err_q;
`else
    logic unused_pluse_us;
    assign unused_pluse_us = pluse_us;
    assign tick_err        = 1'b0;
`endif

endmodule
